frame_buffer_writer: RTL and testbench

//  - Collects shaded pixels from CORES ray cores and issues one frame-buffer memory write per cycle.
//  - Reports how many pixels it accepted each cycle; the renderer sums this count to detect frame completion.
//  - Sits between the ray-core array and the frame-buffer memory write port.
//  - Targets a double-buffered frame buffer selected by the renderer's flip signal.

---
 rtl/renderer_pkg.sv | 25 ++
 rtl/fbw_lane_fifo.sv | 59 +++++
 rtl/frame_buffer_writer.sv | 119 +++++++++++
 tb/tb_frame_buffer_writer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/renderer_pkg.sv
// Shared renderer types and defaults: per-lane shaded pixel and frame-buffer write request.
package renderer_pkg;

  localparam int CORES_DEFAULT     = 4;
  localparam int FB_WIDTH_DEFAULT  = 320;
  localparam int FB_HEIGHT_DEFAULT = 240;
  localparam int SCREEN_COORD      = 10;
  localparam int MEM_ADDR_W        = 32;

  typedef struct packed {
    logic [SCREEN_COORD-1:0] x;
    logic [SCREEN_COORD-1:0] y;
    logic [7:0]              r;
    logic [7:0]              g;
    logic [7:0]              b;
  } shade_out_t;

  typedef struct packed {
    logic                  valid;
    logic [MEM_ADDR_W-1:0] addr;
    logic [31:0]           data;
    logic [3:0]            be;
  } mem_wr_req_t;

endpackage

// File: rtl/fbw_lane_fifo.sv
// Single-push/single-pop first-word-fall-through FIFO for one ray-core lane.
// A push while full is ignored, even if the same cycle pops.
module fbw_lane_fifo
  import renderer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_push,
  input  shade_out_t i_data,
  input  logic       i_pop,
  output shade_out_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  shade_out_t    r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push;
  logic          w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end else begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_mem[r_wr_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/frame_buffer_writer.sv
// Gathers shaded pixels from the ray-core lanes and issues one round-robin frame-buffer write per cycle.
// Optional macro FBW_DOUBLE_BUFFER_EN: flip selects buffer 1 at base FB_WIDTH*FB_HEIGHT.
module frame_buffer_writer
  import renderer_pkg::*;
#(
  parameter int CORES      = renderer_pkg::CORES_DEFAULT,
  parameter int FB_WIDTH   = renderer_pkg::FB_WIDTH_DEFAULT,
  parameter int FB_HEIGHT  = renderer_pkg::FB_HEIGHT_DEFAULT,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = renderer_pkg::MEM_ADDR_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [CORES-1:0] strobe,
  input  logic             flip,
  input  shade_out_t       data [CORES],
  output logic [7:0]       pixel_count,
  output logic             overflow,
  output mem_wr_req_t      mem_request
);

  localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;

  shade_out_t        w_head [CORES];
  logic [CORES-1:0]  w_empty;
  logic [CORES-1:0]  w_full;
  logic [CORES-1:0]  w_pop;
  logic              w_grant;
  logic [PTR_W-1:0]  w_gidx;
  shade_out_t        w_pix;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_addr;

  logic [PTR_W-1:0]  r_rr_ptr;
  logic [7:0]        r_pixel_count;
  logic              r_overflow;
  logic              r_req_valid;
  logic [ADDR_W-1:0] r_req_addr;
  logic [31:0]       r_req_data;

  function automatic logic [PTR_W-1:0] rr_lane(input logic [PTR_W-1:0] base, input int offs);
    return PTR_W'((int'(base) + offs) % CORES);
  endfunction

  for (genvar i = 0; i < CORES; i++) begin : g_lane
    fbw_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (strobe[i]),
      .i_data  (data[i]),
      .i_pop   (w_pop[i]),
      .o_data  (w_head[i]),
      .o_full  (w_full[i]),
      .o_empty (w_empty[i])
    );
    assign w_pop[i] = w_grant && (w_gidx == PTR_W'(i));
  end

  // Round-robin search starting at the pointer; first non-empty lane wins.
  always_comb begin
    w_grant = 1'b0;
    w_gidx  = {PTR_W{1'b0}};
    for (int k = 0; k < CORES; k++) begin
      if (!w_grant && !w_empty[rr_lane(r_rr_ptr, k)]) begin
        w_grant = 1'b1;
        w_gidx  = rr_lane(r_rr_ptr, k);
      end else begin
        w_gidx  = w_gidx;
      end
    end
  end

  assign w_pix      = w_head[w_gidx];
  assign w_in_range = (32'(w_pix.x) < 32'(FB_WIDTH)) && (32'(w_pix.y) < 32'(FB_HEIGHT));

`ifdef FBW_DOUBLE_BUFFER_EN
  assign w_base = flip ? ADDR_W'(FB_WIDTH * FB_HEIGHT) : {ADDR_W{1'b0}};
`else
  logic w_unused_flip;
  assign w_unused_flip = flip;
  assign w_base        = {ADDR_W{1'b0}};
`endif

  assign w_addr = ADDR_W'(32'(w_pix.y) * 32'(FB_WIDTH) + 32'(w_pix.x)) + w_base;

  // Counters, arbitration pointer and the write request register; addr/data hold when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr      <= {PTR_W{1'b0}};
      r_pixel_count <= 8'd0;
      r_overflow    <= 1'b0;
      r_req_valid   <= 1'b0;
      r_req_addr    <= {ADDR_W{1'b0}};
      r_req_data    <= 32'd0;
    end else begin
      r_pixel_count <= 8'($countones(strobe));
      r_overflow    <= r_overflow | (|(strobe & w_full));
      r_req_valid   <= w_grant && w_in_range;
      if (w_grant) begin
        r_rr_ptr   <= rr_lane(w_gidx, 1);
        r_req_addr <= w_addr;
        r_req_data <= {8'h00, w_pix.r, w_pix.g, w_pix.b};
      end else begin
        r_rr_ptr   <= r_rr_ptr;
        r_req_addr <= r_req_addr;
        r_req_data <= r_req_data;
      end
    end
  end

  assign pixel_count       = r_pixel_count;
  assign overflow          = r_overflow;
  assign mem_request.valid = r_req_valid;
  assign mem_request.addr  = r_req_addr;
  assign mem_request.data  = r_req_data;
  assign mem_request.be    = 4'hF;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Self-checking bench for frame_buffer_writer against a queue-based reference model.
module tb_frame_buffer_writer;
  import renderer_pkg::*;

  localparam int NC    = CORES_DEFAULT;
  localparam int W     = FB_WIDTH_DEFAULT;
  localparam int H     = FB_HEIGHT_DEFAULT;
  localparam int DEPTH = 8;
  localparam int FRAME = W * H;

  logic           clk = 1'b0;
  logic           resetn;
  logic [NC-1:0]  strobe;
  logic           flip;
  shade_out_t     data [NC];
  logic [7:0]     pixel_count;
  logic           overflow;
  mem_wr_req_t    mem_request;

  frame_buffer_writer #(.CORES(NC), .FB_WIDTH(W), .FB_HEIGHT(H), .FIFO_DEPTH(DEPTH), .ADDR_W(MEM_ADDR_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .strobe      (strobe),
    .flip        (flip),
    .data        (data),
    .pixel_count (pixel_count),
    .overflow    (overflow),
    .mem_request (mem_request)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // reference model state
  shade_out_t  mq [NC][$];
  int          m_ptr;
  int          m_drops;
  logic        e_valid;
  logic [31:0] e_addr;
  logic [31:0] e_data;
  logic [7:0]  e_pc;
  logic        e_ovf;

  // observation accumulators
  int          sum_pc;
  int          n_writes;
  bit          track;
  byte unsigned hits [2*FRAME];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] buf_base(input logic f);
`ifdef FBW_DOUBLE_BUFFER_EN
    return f ? 32'(FRAME) : 32'd0;
`else
    return 32'd0 & {32{f}};
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NC; i++) mq[i].delete();
    m_ptr   = 0;
    e_valid = 1'b0;
    e_addr  = 32'd0;
    e_data  = 32'd0;
    e_pc    = 8'd0;
    e_ovf   = 1'b0;
  endtask

  // One clock edge of the specified behaviour: pop from the pre-edge queues, then push.
  task automatic model_edge();
    int g = -1;
    int sz [NC];
    shade_out_t p;
    for (int i = 0; i < NC; i++) sz[i] = mq[i].size();
    for (int k = 0; k < NC; k++) begin
      if (g < 0 && sz[(m_ptr + k) % NC] > 0) g = (m_ptr + k) % NC;
    end
    e_pc = 8'($countones(strobe));
    if (g >= 0) begin
      p       = mq[g].pop_front();
      m_ptr   = (g + 1) % NC;
      e_valid = (int'(p.x) < W) && (int'(p.y) < H);
      e_addr  = 32'(int'(p.y) * W + int'(p.x)) + buf_base(flip);
      e_data  = {8'h00, p.r, p.g, p.b};
    end else begin
      e_valid = 1'b0;
    end
    for (int i = 0; i < NC; i++) begin
      if (strobe[i]) begin
        if (sz[i] >= DEPTH) begin
          e_ovf = 1'b1;
          m_drops++;
        end else begin
          mq[i].push_back(data[i]);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", 32'(mem_request.valid), 32'(e_valid));
    if (e_valid) begin
      chk("addr", mem_request.addr, e_addr);
      chk("data", mem_request.data, e_data);
    end
    chk("pixel_count", 32'(pixel_count), 32'(e_pc));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("be", 32'(mem_request.be), 32'hF);
    sum_pc += int'(pixel_count);
    if (mem_request.valid) begin
      n_writes++;
      if (track && mem_request.addr < 32'(2 * FRAME)) hits[mem_request.addr] = hits[mem_request.addr] + 8'd1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    model_clear();
    chk("rst_valid", 32'(mem_request.valid), 32'd0);
    chk("rst_pixel_count", 32'(pixel_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_addr", mem_request.addr, 32'd0);
    chk("rst_data", mem_request.data, 32'd0);
    chk("rst_be", 32'(mem_request.be), 32'hF);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic set_pix(input int lane, input int x, input int y, input int r, input int g, input int b);
    data[lane] = '{x: 10'(x), y: 10'(y), r: 8'(r), g: 8'(g), b: 8'(b)};
  endtask

  initial begin
    resetn = 1'b0;
    strobe = '0;
    flip   = 1'b0;
    for (int i = 0; i < NC; i++) set_pix(i, 0, 0, 0, 0, 0);
    m_drops = 0; sum_pc = 0; n_writes = 0; track = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // all lanes at once after reset: lane order 0..3, no gaps
    for (int i = 0; i < NC; i++) set_pix(i, i, 5, i, 2 * i, 3 * i);
    strobe = 4'hF;
    step();
    chk("all4_count", 32'(pixel_count), 32'd4);
    strobe = 4'h0;
    for (int i = 0; i < NC; i++) begin
      step();
      chk("all4_order_valid", 32'(mem_request.valid), 32'd1);
      chk("all4_order_addr", mem_request.addr, 32'(5 * W + i));
    end
    step();

    // single pixel on lane 0
    set_pix(0, 3, 2, 10, 20, 30);
    strobe = 4'h1;
    step();
    chk("single_count", 32'(pixel_count), 32'd1);
    strobe = 4'h0;
    step();
    chk("single_valid", 32'(mem_request.valid), 32'd1);
    chk("single_addr", mem_request.addr, 32'd643);
    chk("single_data", mem_request.data, 32'h000A141E);

    // buffer select
    set_pix(1, 0, 0, 1, 2, 3);
    flip = 1'b1;
    strobe = 4'h2;
    step();
    strobe = 4'h0;
    step();
`ifdef FBW_DOUBLE_BUFFER_EN
    chk("flip_addr", mem_request.addr, 32'd76800);
`else
    chk("flip_addr", mem_request.addr, 32'd0);
`endif
    flip = 1'b0;

    // out-of-range pixel: counted, not written
    set_pix(2, 320, 0, 9, 9, 9);
    strobe = 4'h4;
    step();
    chk("oor_count", 32'(pixel_count), 32'd1);
    strobe = 4'h0;
    step();
    chk("oor_no_write", 32'(mem_request.valid), 32'd0);

    // randomized traffic
    for (int c = 0; c < 300; c++) begin
      strobe = NC'($urandom);
      flip   = 1'($urandom);
      for (int i = 0; i < NC; i++)
        set_pix(i, $urandom_range(0, 335), $urandom_range(0, 250), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255));
      step();
    end
    strobe = 4'h0;
    repeat (50) step();

    // overflow: lane 0 strobes 12 cycles while the other lanes keep the arbiter busy
    do_reset();
    m_drops = 0; sum_pc = 0; n_writes = 0;
    strobe = 4'hF;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NC; i++) set_pix(i, c, i, c, i, 7);
      step();
    end
    strobe = 4'h0;
    repeat (60) step();
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_counted", 32'(sum_pc), 32'd48);
    chk("ovf_writes", 32'(n_writes), 32'(48 - m_drops));

    // reset while pixels are still queued
    strobe = 4'hF;
    repeat (3) step();
    strobe = 4'h0;
    do_reset();
    n_writes = 0;
    repeat (5) step();
    chk("midrst_no_writes", 32'(n_writes), 32'd0);

    // full frame, one lane per cycle in rotation
    do_reset();
    track = 1'b1; sum_pc = 0; flip = 1'b0;
    for (int p = 0; p < FRAME; p++) begin
      strobe = NC'(1 << (p % NC));
      set_pix(p % NC, p % W, p / W, p, p >> 8, p >> 16);
      step();
    end
    strobe = 4'h0;
    repeat (10) step();
    track = 1'b0;
    chk("frame_count_sum", 32'(sum_pc), 32'(FRAME));
    begin
      int bad = 0;
      for (int a = 0; a < FRAME; a++) if (hits[a] != 8'd1) bad++;
      chk("frame_each_once", 32'(bad), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
